// File: rtl/fwd_hazard_if.sv
// Purpose: bundles the ID/EX forwarding-unit bus (stage write ports, operand
//          requests, mult/div control and the forwarded results / hazard status).
// Modports:
//   master - pipeline side: drives operand requests and stage write info,
//            observes forwarded data, stall, md_busy and stall_cnt
//   slave  - fwd_hazard_unit side (mirror of master)
interface fwd_hazard_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NPORT  = 2,
    parameter int unsigned CNT_W  = 16
);
    logic [NPORT*5-1:0]      src_addr;
    logic [NPORT*DATA_W-1:0] rf_data;
    logic                    ex_wr_en;
    logic [4:0]              ex_wr_addr;
    logic                    ex_is_load;
    logic [DATA_W-1:0]       ex_wr_data;
    logic                    mem_wr_en;
    logic [4:0]              mem_wr_addr;
    logic [DATA_W-1:0]       mem_wr_data;
    logic                    wb_wr_en;
    logic [4:0]              wb_wr_addr;
    logic [DATA_W-1:0]       wb_wr_data;
    logic                    md_start;
    logic                    id_reads_hilo;
    logic                    perf_clr;
    logic [NPORT*DATA_W-1:0] fwd_data;
    logic [NPORT*2-1:0]      fwd_sel;
    logic                    stall;
    logic                    md_busy;
    logic [CNT_W-1:0]        stall_cnt;

    modport master (
        output src_addr, rf_data,
        output ex_wr_en, ex_wr_addr, ex_is_load, ex_wr_data,
        output mem_wr_en, mem_wr_addr, mem_wr_data,
        output wb_wr_en, wb_wr_addr, wb_wr_data,
        output md_start, id_reads_hilo, perf_clr,
        input  fwd_data, fwd_sel, stall, md_busy, stall_cnt
    );

    modport slave (
        input  src_addr, rf_data,
        input  ex_wr_en, ex_wr_addr, ex_is_load, ex_wr_data,
        input  mem_wr_en, mem_wr_addr, mem_wr_data,
        input  wb_wr_en, wb_wr_addr, wb_wr_data,
        input  md_start, id_reads_hilo, perf_clr,
        output fwd_data, fwd_sel, stall, md_busy, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Purpose: ID/EX operand forwarding and hazard detection for the 5-stage pipe.
//          Each source operand takes the youngest in-flight result
//          (EX > MEM > WB > register file), load-use and HI/LO-busy hazards
//          raise stall, and a saturating counter tracks stalled cycles.
// Ports:
//   clk   - pipeline clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - fwd_hazard_if.slave: operand requests, stage write ports,
//           mult/div control, forwarded data/select, stall, md_busy, stall_cnt
module fwd_hazard_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NPORT  = 2,
    parameter int unsigned WB_FWD = 1,
    parameter int unsigned MD_LAT = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    fwd_hazard_if.slave  bus
);
    localparam int unsigned MD_W = $clog2(MD_LAT + 1);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;
    localparam logic [1:0] SEL_WB  = 2'd3;

    logic [NPORT*DATA_W-1:0] w_fwd_data;
    logic [NPORT*2-1:0]      w_fwd_sel;
    logic [NPORT-1:0]        w_load_use;
    logic                    w_md_busy;
    logic                    w_stall;
    logic [MD_W-1:0]         r_md_cnt;
    logic [CNT_W-1:0]        r_stall_cnt;

    // Per-operand source selection; r0 never forwards.
    for (genvar g = 0; g < NPORT; g++) begin : g_port
        logic [4:0]        w_src;
        logic              w_ex_hit;
        logic              w_mem_hit;
        logic              w_wb_hit;
        logic [1:0]        w_sel;
        logic [DATA_W-1:0] w_data;

        assign w_src     = bus.src_addr[5*g +: 5];
        assign w_ex_hit  = bus.ex_wr_en  && (bus.ex_wr_addr  == w_src) && (w_src != 5'd0);
        assign w_mem_hit = bus.mem_wr_en && (bus.mem_wr_addr == w_src) && (w_src != 5'd0);
        assign w_wb_hit  = (WB_FWD != 0) && bus.wb_wr_en && (bus.wb_wr_addr == w_src)
                           && (w_src != 5'd0);
        assign w_load_use[g] = w_ex_hit && bus.ex_is_load;

        // A load in EX shadows older stages: the operand is stalled, not forwarded from MEM/WB.
        always_comb begin
            w_sel  = SEL_RF;
            w_data = bus.rf_data[DATA_W*g +: DATA_W];
            if (w_ex_hit) begin
                if (!bus.ex_is_load) begin
                    w_sel  = SEL_EX;
                    w_data = bus.ex_wr_data;
                end
            end else if (w_mem_hit) begin
                w_sel  = SEL_MEM;
                w_data = bus.mem_wr_data;
            end else if (w_wb_hit) begin
                w_sel  = SEL_WB;
                w_data = bus.wb_wr_data;
            end
        end

        assign w_fwd_sel[2*g +: 2]           = w_sel;
        assign w_fwd_data[DATA_W*g +: DATA_W] = w_data;
    end

    // Mult/div latency counter; a new start restarts the full latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_cnt <= '0;
        end else if (bus.md_start) begin
            r_md_cnt <= MD_W'(MD_LAT);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - MD_W'(1);
        end
    end

    // HI/LO is readable in the final count cycle, so busy clears one cycle before the count does.
    assign w_md_busy = (r_md_cnt > MD_W'(1));

    assign w_stall = (|w_load_use) | (bus.id_reads_hilo & w_md_busy);

    // Saturating stall-cycle counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (bus.perf_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.fwd_data  = w_fwd_data;
    assign bus.fwd_sel   = w_fwd_sel;
    assign bus.stall     = w_stall;
    assign bus.md_busy   = w_md_busy;
    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Purpose: directed bench for fwd_hazard_unit. Two instances share one stimulus:
//          dut_a (WB_FWD=1, MD_LAT=4, CNT_W=4) and dut_b (WB_FWD=0, MD_LAT=8, CNT_W=16).
//          A behavioural model is compared every cycle; pinned literals anchor the model.
module tb_fwd_hazard_unit;
    localparam int unsigned DW = 32;
    localparam int unsigned NP = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  src_addr;
    logic [63:0] rf_data;
    logic        ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en;
    logic [4:0]  ex_wr_addr, mem_wr_addr, wb_wr_addr;
    logic [31:0] ex_wr_data, mem_wr_data, wb_wr_data;
    logic        md_start, id_reads_hilo, perf_clr;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    int cyc       = 0;
    int m_start_a = -1000;
    int m_start_b = -1000;
    int m_cnt_a   = 0;
    int m_cnt_b   = 0;

    always #5 clk = ~clk;

    fwd_hazard_if #(.DATA_W(DW), .NPORT(NP), .CNT_W(4))  if_a ();
    fwd_hazard_if #(.DATA_W(DW), .NPORT(NP), .CNT_W(16)) if_b ();

    assign if_a.src_addr = src_addr;       assign if_b.src_addr = src_addr;
    assign if_a.rf_data = rf_data;         assign if_b.rf_data = rf_data;
    assign if_a.ex_wr_en = ex_wr_en;       assign if_b.ex_wr_en = ex_wr_en;
    assign if_a.ex_wr_addr = ex_wr_addr;   assign if_b.ex_wr_addr = ex_wr_addr;
    assign if_a.ex_is_load = ex_is_load;   assign if_b.ex_is_load = ex_is_load;
    assign if_a.ex_wr_data = ex_wr_data;   assign if_b.ex_wr_data = ex_wr_data;
    assign if_a.mem_wr_en = mem_wr_en;     assign if_b.mem_wr_en = mem_wr_en;
    assign if_a.mem_wr_addr = mem_wr_addr; assign if_b.mem_wr_addr = mem_wr_addr;
    assign if_a.mem_wr_data = mem_wr_data; assign if_b.mem_wr_data = mem_wr_data;
    assign if_a.wb_wr_en = wb_wr_en;       assign if_b.wb_wr_en = wb_wr_en;
    assign if_a.wb_wr_addr = wb_wr_addr;   assign if_b.wb_wr_addr = wb_wr_addr;
    assign if_a.wb_wr_data = wb_wr_data;   assign if_b.wb_wr_data = wb_wr_data;
    assign if_a.md_start = md_start;       assign if_b.md_start = md_start;
    assign if_a.id_reads_hilo = id_reads_hilo; assign if_b.id_reads_hilo = id_reads_hilo;
    assign if_a.perf_clr = perf_clr;       assign if_b.perf_clr = perf_clr;

    fwd_hazard_unit #(.DATA_W(DW), .NPORT(NP), .WB_FWD(1), .MD_LAT(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a));
    fwd_hazard_unit #(.DATA_W(DW), .NPORT(NP), .WB_FWD(0), .MD_LAT(8), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));

    // ---------------- behavioural model ----------------
    function automatic logic [4:0] m_src(int p);
        logic [9:0] s;
        s = src_addr;
        return s[5*p +: 5];
    endfunction

    function automatic logic [1:0] m_sel(int p, bit wb_fwd);
        logic [4:0] a;
        a = m_src(p);
        if (a == 5'd0) return 2'd0;
        if (ex_wr_en && ex_wr_addr == a) return ex_is_load ? 2'd0 : 2'd1;
        if (mem_wr_en && mem_wr_addr == a) return 2'd2;
        if (wb_fwd && wb_wr_en && wb_wr_addr == a) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [31:0] m_data(int p, bit wb_fwd);
        logic [63:0] rf;
        rf = rf_data;
        case (m_sel(p, wb_fwd))
            2'd1:    return ex_wr_data;
            2'd2:    return mem_wr_data;
            2'd3:    return wb_wr_data;
            default: return rf[32*p +: 32];
        endcase
    endfunction

    // HI/LO busy for the cycles strictly between the start cycle and start+lat.
    function automatic bit m_busy(int lat, int start);
        int d;
        d = cyc - start;
        return (d >= 1) && (d <= lat - 1);
    endfunction

    function automatic bit m_stall(bit busy);
        bit lu;
        lu = 1'b0;
        for (int p = 0; p < 2; p++)
            if (m_src(p) != 5'd0 && ex_wr_en && ex_is_load && ex_wr_addr == m_src(p)) lu = 1'b1;
        return lu || (id_reads_hilo && busy);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_start_a <= -1000;
            m_start_b <= -1000;
            m_cnt_a   <= 0;
            m_cnt_b   <= 0;
        end else begin
            if (perf_clr) m_cnt_a <= 0;
            else if (m_stall(m_busy(4, m_start_a)) && m_cnt_a < 15) m_cnt_a <= m_cnt_a + 1;
            if (perf_clr) m_cnt_b <= 0;
            else if (m_stall(m_busy(8, m_start_b)) && m_cnt_b < 65535) m_cnt_b <= m_cnt_b + 1;
            if (md_start) begin
                m_start_a <= cyc;
                m_start_b <= cyc;
            end
            cyc <= cyc + 1;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        bit ba, bb;
        logic [3:0]  sa, sb;
        logic [63:0] da, db;
        ba = m_busy(4, m_start_a);
        bb = m_busy(8, m_start_b);
        sa = if_a.fwd_sel;  sb = if_b.fwd_sel;
        da = if_a.fwd_data; db = if_b.fwd_data;
        for (int p = 0; p < 2; p++) begin
            chk("sel_a",  64'(sa[2*p +: 2]),  64'(m_sel(p, 1'b1)));
            chk("data_a", 64'(da[32*p +: 32]), 64'(m_data(p, 1'b1)));
            chk("sel_b",  64'(sb[2*p +: 2]),  64'(m_sel(p, 1'b0)));
            chk("data_b", 64'(db[32*p +: 32]), 64'(m_data(p, 1'b0)));
        end
        chk("stall_a", 64'(if_a.stall),     64'(m_stall(ba)));
        chk("stall_b", 64'(if_b.stall),     64'(m_stall(bb)));
        chk("busy_a",  64'(if_a.md_busy),   64'(ba));
        chk("busy_b",  64'(if_b.md_busy),   64'(bb));
        chk("cnt_a",   64'(if_a.stall_cnt), 64'(m_cnt_a));
        chk("cnt_b",   64'(if_b.stall_cnt), 64'(m_cnt_b));
    endtask

    task automatic settle();
        @(negedge clk);
        compare_all();
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        src_addr = '0;
        rf_data  = 64'hA0A0_0001_B0B0_0000;
        ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = '0; ex_wr_data = '0;
        mem_wr_en = 0; mem_wr_addr = '0; mem_wr_data = '0;
        wb_wr_en = 0; wb_wr_addr = '0; wb_wr_data = '0;
        md_start = 0; id_reads_hilo = 0; perf_clr = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        settle();
        chk("pin_rst_cnt_a", 64'(if_a.stall_cnt), 64'd0);
        chk("pin_rst_busy_b", 64'(if_b.md_busy), 64'd0);
        next();
        rst_n = 1'b1;

        // priority: EX > MEM > WB, both ports naming r8
        src_addr = {5'd8, 5'd8};
        ex_wr_en = 1; ex_wr_addr = 5'd8; ex_wr_data = 32'h11;
        mem_wr_en = 1; mem_wr_addr = 5'd8; mem_wr_data = 32'h22;
        wb_wr_en = 1; wb_wr_addr = 5'd8; wb_wr_data = 32'h33;
        settle();
        chk("pin_prio_ex_sel", 64'(if_a.fwd_sel), 64'h5);
        chk("pin_prio_ex_data", 64'(if_a.fwd_data), 64'h0000_0011_0000_0011);
        next();
        ex_wr_en = 0;
        settle();
        chk("pin_prio_mem_sel", 64'(if_b.fwd_sel), 64'hA);
        chk("pin_prio_mem_data", 64'(if_a.fwd_data), 64'h0000_0022_0000_0022);
        next();
        // only WB matches: forwarded in dut_a, disabled in dut_b
        mem_wr_en = 0;
        settle();
        chk("pin_wb_sel_a", 64'(if_a.fwd_sel), 64'hF);
        chk("pin_wb_sel_b", 64'(if_b.fwd_sel), 64'h0);
        chk("pin_wb_data_b", 64'(if_b.fwd_data), 64'hA0A0_0001_B0B0_0000);
        next();

        // zero register never forwards
        clear_inputs();
        ex_wr_en = 1; ex_wr_addr = 5'd0; ex_wr_data = 32'hFF;
        settle();
        chk("pin_r0_sel", 64'(if_a.fwd_sel), 64'h0);
        chk("pin_r0_data", 64'(if_a.fwd_data), 64'hA0A0_0001_B0B0_0000);
        next();

        // load-use on rt=r5, MEM also has r5 but must not be used
        clear_inputs();
        src_addr = {5'd5, 5'd3};
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5'd5; ex_wr_data = 32'hDEAD;
        mem_wr_en = 1; mem_wr_addr = 5'd5; mem_wr_data = 32'h44;
        settle();
        chk("pin_lu_stall", 64'(if_a.stall), 64'd1);
        chk("pin_lu_sel", 64'(if_a.fwd_sel), 64'h0);
        next();
        ex_wr_en = 0; ex_is_load = 0;
        mem_wr_data = 32'h5A5A;
        settle();
        chk("pin_lu_after_stall", 64'(if_a.stall), 64'd0);
        chk("pin_lu_after_sel", 64'(if_a.fwd_sel), 64'h8);
        chk("pin_lu_cnt_a", 64'(if_a.stall_cnt), 64'd1);
        next();

        // mult/div: start at cycle 0, MFHI held from cycle 1
        clear_inputs();
        md_start = 1;
        settle(); next();
        md_start = 0; id_reads_hilo = 1;
        for (int c = 1; c <= 4; c++) begin
            settle();
            chk("pin_md_stall_a", 64'(if_a.stall), (c <= 3) ? 64'd1 : 64'd0);
            next();
        end
        id_reads_hilo = 0;
        for (int k = 0; k < 8; k++) begin settle(); next(); end
        settle();
        chk("pin_md_cnt_a", 64'(if_a.stall_cnt), 64'd4);
        chk("pin_md_cnt_b", 64'(if_b.stall_cnt), 64'd5);
        next();

        // restart at cycle 2 extends busy through cycle 5
        md_start = 1;
        settle(); next();
        md_start = 0;
        settle(); next();
        md_start = 1;
        settle(); next();
        md_start = 0;
        for (int c = 3; c <= 6; c++) begin
            settle();
            chk("pin_md_busy_a", 64'(if_a.md_busy), (c <= 5) ? 64'd1 : 64'd0);
            next();
        end
        for (int k = 0; k < 8; k++) begin settle(); next(); end

        // asynchronous reset with dut_b mid-count (count 5)
        md_start = 1;
        settle(); next();
        md_start = 0;
        for (int c = 1; c <= 3; c++) begin settle(); next(); end
        settle();
        chk("pin_pre_rst_busy_b", 64'(if_b.md_busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("pin_async_busy_b", 64'(if_b.md_busy), 64'd0);
        chk("pin_async_cnt_a", 64'(if_a.stall_cnt), 64'd0);
        chk("pin_async_cnt_b", 64'(if_b.stall_cnt), 64'd0);
        next();
        rst_n = 1'b1;
        settle(); next();

        // saturation: hold a load-use stall for 20 cycles
        clear_inputs();
        src_addr = {5'd5, 5'd0};
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5'd5;
        for (int k = 0; k < 20; k++) begin settle(); next(); end
        settle();
        chk("pin_sat_cnt_a", 64'(if_a.stall_cnt), 64'd15);
        chk("pin_sat_cnt_b", 64'(if_b.stall_cnt), 64'd20);
        perf_clr = 1;
        next();
        settle();
        chk("pin_clr_cnt_a", 64'(if_a.stall_cnt), 64'd0);
        chk("pin_clr_cnt_b", 64'(if_b.stall_cnt), 64'd0);
        perf_clr = 0;
        next();
        settle();
        chk("pin_post_clr_cnt_a", 64'(if_a.stall_cnt), 64'd1);
        next();

        clear_inputs();
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
